alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter: TAG_WIDTH, default 6, width of the reorder/rename tag carried with each operation.
REQ-002 i_clock  input  1  single clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-high.
REQ-004 i_flush  input  1  synchronous pipeline flush (mispredict); discards held operation.
REQ-005 i_req_valid  input  2  per-requester (reservation station 0/1) operation valid.
REQ-006 i_req_data_1, i_req_data_2, i_req_address, i_req_immediate  input  2x32 each  per-requester operands.
REQ-007 i_req_instr_name  input  2 x instr_name_e  per-requester operation.
REQ-008 i_req_tag  input  2xTAG_WIDTH  per-requester destination tag.
REQ-009 o_req_ready  output  2  per-requester accept; transfer when valid and ready both 1.
REQ-010 o_alu_data_1, o_alu_data_2, o_alu_address, o_alu_immediate  output  32 each  operands to the shared ALU.
REQ-011 o_alu_instr_name  output  instr_name_e  operation to the shared ALU.
REQ-012 i_alu_result  input  32  combinational ALU result.
REQ-013 o_cdb_request  output  1  request to broadcast on the common data bus.
REQ-014 i_cdb_grant  input  1  CDB grant; broadcast completes on an edge where request and grant are both 1.
REQ-015 o_cdb_result  output  32, o_cdb_tag  output  TAG_WIDTH  broadcast payload.

Function
REQ-016 FSM states: IDLE, EXEC, BROADCAST.
REQ-017 IDLE: if any i_req_valid, accept the round-robin winner, latch its operands/name/tag into the op register, go EXEC; else stay.
REQ-018 EXEC: op register drives o_alu_*; at the edge, capture i_alu_result and op tag into the result register, go BROADCAST; exactly one cycle in EXEC.
REQ-019 BROADCAST: o_cdb_request=1, o_cdb_result/o_cdb_tag from result register, stable until granted.
REQ-020 BROADCAST with i_cdb_grant=1: if any i_req_valid, accept winner in the same cycle and go EXEC (back-to-back); else go IDLE.
REQ-021 BROADCAST with i_cdb_grant=0: hold state and payload; o_req_ready=0.
REQ-022 o_req_ready combinational: 1 only for the arbitration winner, only in IDLE or in BROADCAST with i_cdb_grant=1, and only if i_flush=0 and i_reset=0; at most one bit set.
REQ-023 Arbitration: round-robin over 2 requesters; priority pointer names the preferred requester; if only one valid it wins regardless of pointer.
REQ-024 Pointer updates only on an accepted transfer, to the requester not granted; unchanged otherwise.
REQ-025 Latency: accept at edge N, result captured at N+1, o_cdb_request high in cycle after N+1; with immediate grant, max throughput one op per 2 cycles.
REQ-026 o_alu_* driven from the op register in all states; op register written only on acceptance.
REQ-027 Result captured unmodified (32 bits, no extension); scheduler does not interpret instr_name.
REQ-028 i_flush=1 (any state): next state IDLE, no acceptance that cycle, pending broadcast dropped, o_cdb_request low the following cycle; pointer unchanged.
REQ-029 Flush and grant in the same BROADCAST cycle: flush wins, no new acceptance, go IDLE.
REQ-030 Requester valid deasserted while not ready: no state effect (no stored request).

Reset
REQ-031 i_reset=1 at an edge: state IDLE, pointer = requester 0, op and result registers 0, o_alu_instr_name = encoding 0, o_cdb_tag = 0.
REQ-032 During reset cycle o_req_ready=0 and o_cdb_request=0; reset overrides flush and grant; reset mid-operation discards the operation.

Verification
REQ-033 Single: req0 ADD 5,7 tag 3, grant tied 1 -> ready0 at N, cdb_request at N+2 with result 12 tag 3, then IDLE.
REQ-034 Contention: both valid continuously, grant 1 -> acceptances alternate 0,1,0,1 starting with 0 after reset; ops every 2 cycles.
REQ-035 Backpressure: result SUB 10,3 tag 9, grant 0 for 4 cycles -> request/result 7/tag 9 stable, ready 0 throughout; grant 1 with req1 valid -> req1 accepted same cycle.
REQ-036 Flush: flush during EXEC of tag 4 -> no broadcast of tag 4, IDLE next cycle, pointer unchanged.
REQ-037 Reset mid-BROADCAST -> request 0, outputs 0, next acceptance goes to req0 when both valid.

Source files
------------

// File: rtl/alu_scheduler.sv
// ============================================================================
// Module      : alu_scheduler (with alu_scheduler_pkg)
// Description : Arbitrates two reservation stations onto one shared ALU,
//               holds one operation in flight and broadcasts its result on
//               the common data bus (IDLE -> EXEC -> BROADCAST).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_scheduler_pkg;
  // Operation names carried through the scheduler; encoding 0 is the reset value.
  typedef enum logic [3:0] {
    INSTR_NOP   = 4'd0,
    INSTR_ADD   = 4'd1,
    INSTR_SUB   = 4'd2,
    INSTR_AND   = 4'd3,
    INSTR_OR    = 4'd4,
    INSTR_XOR   = 4'd5,
    INSTR_ADDI  = 4'd6,
    INSTR_LUI   = 4'd7,
    INSTR_AUIPC = 4'd8
  } instr_name_e;
endpackage

module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int TAG_WIDTH = 6
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic [1:0]                i_req_valid,
  input  logic [1:0][31:0]          i_req_data_1,
  input  logic [1:0][31:0]          i_req_data_2,
  input  logic [1:0][31:0]          i_req_address,
  input  logic [1:0][31:0]          i_req_immediate,
  input  instr_name_e [1:0]         i_req_instr_name,
  input  logic [1:0][TAG_WIDTH-1:0] i_req_tag,
  output logic [1:0]                o_req_ready,
  output logic [31:0]               o_alu_data_1,
  output logic [31:0]               o_alu_data_2,
  output logic [31:0]               o_alu_address,
  output logic [31:0]               o_alu_immediate,
  output instr_name_e               o_alu_instr_name,
  input  logic [31:0]               i_alu_result,
  output logic                      o_cdb_request,
  input  logic                      i_cdb_grant,
  output logic [31:0]               o_cdb_result,
  output logic [TAG_WIDTH-1:0]      o_cdb_tag
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXEC      = 2'd1,
    BROADCAST = 2'd2
  } state_e;

  state_e                 state;
  state_e                 state_next;
  logic                   prio_ptr;      // preferred requester when both are valid
  logic                   any_valid;
  logic                   winner;
  logic                   accept_window; // state allows a new operation this cycle
  logic                   accept;

  logic [31:0]            op_data_1;
  logic [31:0]            op_data_2;
  logic [31:0]            op_address;
  logic [31:0]            op_immediate;
  instr_name_e            op_instr_name;
  logic [TAG_WIDTH-1:0]   op_tag;

  logic [31:0]            res_value;
  logic [TAG_WIDTH-1:0]   res_tag;

  // Round-robin pick: a lone requester always wins, otherwise the pointer decides.
  always_comb begin
    any_valid = |i_req_valid;
    winner    = 1'b0;
    if (&i_req_valid) begin
      winner = prio_ptr;
    end else if (i_req_valid[1]) begin
      winner = 1'b1;
    end
  end

  // Next-state, acceptance and handshake outputs; flush forces IDLE and blocks acceptance.
  always_comb begin
    state_next    = state;
    accept_window = 1'b0;
    case (state)
      IDLE: begin
        accept_window = 1'b1;
        if (any_valid) state_next = EXEC;
      end
      EXEC: begin
        state_next = BROADCAST;
      end
      BROADCAST: begin
        if (i_cdb_grant) begin
          accept_window = 1'b1;
          state_next    = any_valid ? EXEC : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (i_flush) state_next = IDLE;

    accept        = accept_window && any_valid && !i_flush && !i_reset;
    o_req_ready   = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
    o_cdb_request = (state == BROADCAST) && !i_reset;
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Priority pointer moves to the requester that was not served.
  always_ff @(posedge i_clock) begin
    if (i_reset)     prio_ptr <= 1'b0;
    else if (accept) prio_ptr <= ~winner;
  end

  // Op register: loaded only when an operation is accepted.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      op_data_1     <= '0;
      op_data_2     <= '0;
      op_address    <= '0;
      op_immediate  <= '0;
      op_instr_name <= INSTR_NOP;
      op_tag        <= '0;
    end else if (accept) begin
      op_data_1     <= i_req_data_1[winner];
      op_data_2     <= i_req_data_2[winner];
      op_address    <= i_req_address[winner];
      op_immediate  <= i_req_immediate[winner];
      op_instr_name <= i_req_instr_name[winner];
      op_tag        <= i_req_tag[winner];
    end
  end

  // Result register: captures the ALU output at the end of the single EXEC cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      res_value <= '0;
      res_tag   <= '0;
    end else if (state == EXEC && !i_flush) begin
      res_value <= i_alu_result;
      res_tag   <= op_tag;
    end
  end

  assign o_alu_data_1     = op_data_1;
  assign o_alu_data_2     = op_data_2;
  assign o_alu_address    = op_address;
  assign o_alu_immediate  = op_immediate;
  assign o_alu_instr_name = op_instr_name;
  assign o_cdb_result     = res_value;
  assign o_cdb_tag        = res_tag;

endmodule

`default_nettype wire

// File: tb/tb_alu_scheduler.sv
// ============================================================================
// Module      : tb_alu_scheduler
// Description : Self-checking bench for alu_scheduler: directed scenarios plus
//               randomized traffic against a transaction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  localparam int TW = 6;

  logic                clk;
  logic                rst;
  logic                flush;
  logic [1:0]          req_valid;
  logic [1:0][31:0]    req_d1;
  logic [1:0][31:0]    req_d2;
  logic [1:0][31:0]    req_addr;
  logic [1:0][31:0]    req_imm;
  instr_name_e [1:0]   req_name;
  logic [1:0][TW-1:0]  req_tag;
  logic [1:0]          req_ready;
  logic [31:0]         alu_d1, alu_d2, alu_addr, alu_imm;
  instr_name_e         alu_name;
  logic [31:0]         alu_result;
  logic                cdb_request;
  logic                cdb_grant;
  logic [31:0]         cdb_result;
  logic [TW-1:0]       cdb_tag;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: one operation in flight, described by its age.
  bit                  m_busy;
  int                  m_age;       // edges since acceptance (0 = executing)
  bit                  m_ptr;
  bit                  m_known;     // result register contents are predictable
  logic [31:0]         m_d1, m_d2, m_addr, m_imm;
  instr_name_e         m_name;
  logic [TW-1:0]       m_op_tag;
  logic [31:0]         m_res;
  logic [TW-1:0]       m_tag;

  alu_scheduler #(.TAG_WIDTH(TW)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_flush          (flush),
    .i_req_valid      (req_valid),
    .i_req_data_1     (req_d1),
    .i_req_data_2     (req_d2),
    .i_req_address    (req_addr),
    .i_req_immediate  (req_imm),
    .i_req_instr_name (req_name),
    .i_req_tag        (req_tag),
    .o_req_ready      (req_ready),
    .o_alu_data_1     (alu_d1),
    .o_alu_data_2     (alu_d2),
    .o_alu_address    (alu_addr),
    .o_alu_immediate  (alu_imm),
    .o_alu_instr_name (alu_name),
    .i_alu_result     (alu_result),
    .o_cdb_request    (cdb_request),
    .i_cdb_grant      (cdb_grant),
    .o_cdb_result     (cdb_result),
    .o_cdb_tag        (cdb_tag)
  );

  // Behavioural shared ALU.
  function automatic logic [31:0] ref_alu(input instr_name_e n, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] ad,
                                          input logic [31:0] im);
    case (n)
      INSTR_ADD:   return a + b;
      INSTR_SUB:   return a - b;
      INSTR_AND:   return a & b;
      INSTR_OR:    return a | b;
      INSTR_XOR:   return a ^ b;
      INSTR_ADDI:  return a + im;
      INSTR_LUI:   return im;
      INSTR_AUIPC: return ad + im;
      default:     return 32'd0;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_name, alu_d1, alu_d2, alu_addr, alu_imm);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_ptr = 0; m_known = 1;
    m_d1 = '0; m_d2 = '0; m_addr = '0; m_imm = '0; m_name = INSTR_NOP; m_op_tag = '0;
    m_res = '0; m_tag = '0;
  endtask

  task automatic set_req(input int i, input instr_name_e n, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] t);
    req_name[i] = n; req_d1[i] = a; req_d2[i] = b;
    req_addr[i] = $urandom; req_imm[i] = $urandom; req_tag[i] = t;
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < 2; i++)
      set_req(i, instr_name_e'($urandom_range(0, 8)), $urandom, $urandom, TW'($urandom));
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic [1:0] v, input logic g, input logic f, input logic r);
    bit         open_w;
    bit         win;
    logic [1:0] exp_ready;
    bit         exp_req;
    @(negedge clk);
    req_valid = v; cdb_grant = g; flush = f; rst = r;
    #1;
    open_w    = !r && !f && (v != 2'b00) && (!m_busy || (m_age >= 1 && g));
    win       = (v == 2'b11) ? m_ptr : v[1];
    exp_ready = open_w ? (win ? 2'b10 : 2'b01) : 2'b00;
    exp_req   = m_busy && (m_age >= 1) && !r;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("cdb_request", 32'(cdb_request), 32'(exp_req));
    if (m_known) begin
      check("cdb_result", cdb_result, m_res);
      check("cdb_tag", 32'(cdb_tag), 32'(m_tag));
    end
    check("alu_data_1", alu_d1, m_d1);
    check("alu_data_2", alu_d2, m_d2);
    check("alu_imm", alu_imm, m_imm);
    check("alu_name", 32'(alu_name), 32'(m_name));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (f) begin
      m_busy = 0; m_known = 0;
    end else if (open_w) begin
      m_d1 = req_d1[win]; m_d2 = req_d2[win]; m_addr = req_addr[win];
      m_imm = req_imm[win]; m_name = req_name[win]; m_op_tag = req_tag[win];
      m_busy = 1; m_age = 0; m_ptr = !win; m_known = 0;
    end else if (m_busy && m_age >= 1 && g) begin
      m_busy = 0;
    end else if (m_busy && m_age == 0) begin
      m_age = 1; m_known = 1;
      m_res = ref_alu(m_name, m_d1, m_d2, m_addr, m_imm); m_tag = m_op_tag;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cdb_grant = 1'b0; req_valid = 2'b00;
    rand_reqs();
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state.
    step(2'b00, 1'b1, 1'b0, 1'b1);
    check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("rst_alu_name", 32'(alu_name), 32'd0);

    // Single ADD 5+7 tag 3 with grant tied high.
    set_req(0, INSTR_ADD, 32'd5, 32'd7, 6'd3);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("single_req", 32'(cdb_request), 32'd1);
    check("single_res", cdb_result, 32'd12);
    check("single_tag", 32'(cdb_tag), 32'd3);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);

    // Contention: acceptances alternate starting with requester 0.
    step(2'b00, 1'b1, 1'b0, 1'b1);
    set_req(0, INSTR_ADD, 32'd1, 32'd1, 6'd10);
    set_req(1, INSTR_ADD, 32'd2, 32'd2, 6'd20);
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b0, 1'b0);
      check("rr_tag", 32'(cdb_tag), (k % 2 == 0) ? 32'd10 : 32'd20);
    end

    // Backpressure: SUB 10-3 tag 9 held for four ungranted cycles.
    step(2'b00, 1'b1, 1'b0, 1'b1);
    set_req(0, INSTR_SUB, 32'd10, 32'd3, 6'd9);
    set_req(1, INSTR_OR, 32'h0f0, 32'h00f, 6'd17);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("bp_req", 32'(cdb_request), 32'd1);
      check("bp_res", cdb_result, 32'd7);
      check("bp_tag", 32'(cdb_tag), 32'd9);
      step(2'b10, 1'b0, 1'b0, 1'b0);
    end
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check("bp_alu_d1", alu_d1, 32'h0f0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("bp_next_tag", 32'(cdb_tag), 32'd17);
    step(2'b00, 1'b1, 1'b0, 1'b0);

    // Flush during EXEC of tag 4: nothing broadcast, pointer keeps favouring req1.
    step(2'b00, 1'b1, 1'b0, 1'b1);
    set_req(0, INSTR_ADD, 32'd4, 32'd4, 6'd4);
    set_req(1, INSTR_XOR, 32'd6, 32'd3, 6'd33);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b1, 1'b0);
    check("flush_req", 32'(cdb_request), 32'd0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("flush_ptr_tag", 32'(cdb_tag), 32'd33);
    check("flush_ptr_res", cdb_result, 32'd5);

    // Reset in the middle of a broadcast.
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0, 1'b1);
    check("rstmid_req", 32'(cdb_request), 32'd0);
    check("rstmid_tag", 32'(cdb_tag), 32'd0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("rstmid_next_tag", 32'(cdb_tag), 32'd4);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 2000; c++) begin
      rand_reqs();
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
